// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C EEPROM responder and its line conditioner.
//   i2c_state_e   : responder FSM state encoding (also exported for debug)
//   I2C_ACK/NACK  : SDA level of an acknowledge / not-acknowledge bit
//   BITS_PER_BYTE : data bits clocked before each acknowledge slot
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA pad levels into the clk domain and decodes
// bus events. Events are combinational from registered levels, so the FSM
// acts on them three clk edges after the pin changed.
//   clk, rst     : system clock, synchronous active-high reset
//   scl_i, sda_i : raw pad levels
//   scl_rise_o   : synchronized SCL rising edge (one clk)
//   scl_fall_o   : synchronized SCL falling edge (one clk)
//   start_det_o  : SDA fell while SCL was high
//   stop_det_o   : SDA rose while SCL was high
//   sda_s_o      : synchronized SDA level
// ---------------------------------------------------------------------------
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;

  // Reset to the idle-bus level (both high) so leaving reset never looks
  // like a bus edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s   = scl_sync_q[1];
  assign sda_s_o = sda_sync_q[1];

  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;

  // SCL must be high in both the previous and current cycle: an SDA edge
  // that coincides with an SCL edge is ordinary data, not START/STOP.
  assign start_det_o = scl_prev_q & scl_s & sda_prev_q & ~sda_s_o;
  assign stop_det_o  = scl_prev_q & scl_s & ~sda_prev_q & sda_s_o;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C responder emulating a 24Cxx EEPROM with a one-byte word address:
// byte/page write, current-address read, random read and sequential read.
// SDA is driven open-drain through sda_oe.
//   clk, rst   : system clock (>= 8x SCL), synchronous active-high reset
//   scl_i      : SCL pad level
//   sda_i      : SDA pad level
//   sda_oe     : 1 = pull SDA low, 0 = release
//   wr_strobe  : one-clk pulse per committed byte, with wr_addr / wr_data
//   busy       : addressed and inside a transfer
//   dbg_state  : current FSM state
//
// Handshake: the I2C bus has no valid/ready pair; a byte transfer is eight
// bits sampled on SCL rise, then an acknowledge slot driven from the SCL fall
// after bit 8 until the SCL fall after the 9th clock. wr_strobe is a
// fire-and-forget pulse; the consumer must accept it in that cycle.
// ---------------------------------------------------------------------------
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 256,
  parameter int         AW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output i2c_state_e    dbg_state
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_s_o     (sda_s)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          mem_we;
  logic          load_rd;

  logic [7:0]    mem_q [MEM_DEPTH];
  logic [7:0]    mem_rdata;

  logic byte_done;
  logic addr_match;

  assign mem_rdata  = mem_q[ptr_q];
  assign byte_done  = scl_fall && (bit_cnt_q == BITS_PER_BYTE);
  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

  // Next-state logic. Bus conditions override everything else.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_DEV_ADDR;
    end else begin
      case (state_q)
        ST_DEV_ADDR:  if (byte_done) state_d = addr_match ? ST_DEV_ACK : ST_WAIT_STOP;
        // shift_q still holds the address byte, so bit 0 is R/W.
        ST_DEV_ACK:   if (scl_fall) state_d = shift_q[0] ? ST_RD_DATA : ST_WORD_ADDR;
        ST_WORD_ADDR: if (byte_done) state_d = ST_WADDR_ACK;
        ST_WADDR_ACK: if (scl_fall) state_d = ST_WR_DATA;
        ST_WR_DATA:   if (byte_done) state_d = ST_WR_ACK;
        ST_WR_ACK:    if (scl_fall) state_d = ST_WR_DATA;
        ST_RD_DATA:   if (scl_fall && (bit_cnt_q == 4'd7)) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && (sda_s == I2C_NACK)) state_d = ST_WAIT_STOP;
          else if (scl_fall)                   state_d = ST_RD_DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath / output logic.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    load_rd     = 1'b0;

    if (stop_det || start_det) begin
      // Either condition ends the current transfer; ptr is kept so a
      // repeated START can follow a dummy write (random read).
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
          if (scl_rise && (bit_cnt_q != BITS_PER_BYTE)) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            if (state_q == ST_DEV_ADDR) begin
              if (addr_match) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end
            end else if (state_q == ST_WORD_ADDR) begin
              ptr_d    = shift_q[AW-1:0];
              sda_oe_d = 1'b1;
            end else begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = shift_q;
              ptr_d       = ptr_q + 1'b1;
              sda_oe_d    = 1'b1;
            end
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall) begin
            if (shift_q[0]) load_rd  = 1'b1;
            else            sda_oe_d = 1'b0;
          end
        end
        ST_WADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b0;
        end
        ST_RD_DATA: begin
          // shift_q[7] is the bit on the wire; bit_cnt counts bits already
          // presented, and the 8th fall hands the bus to the master's ACK.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && (sda_s == I2C_NACK)) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end else if (scl_fall) begin
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_rd) begin
      shift_d   = mem_rdata;
      ptr_d     = ptr_q + 1'b1;
      sda_oe_d  = ~mem_rdata[7];
      bit_cnt_d = '0;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Bit-banged I2C master against i2c_eeprom_slave on a wired-AND SDA line.
// Committed writes and read bytes are predicted into queues and checked when
// the DUT strobes a write or the master finishes receiving a byte.
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_slave;
  import i2c_pkg::*;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---- bus ----
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  i2c_state_e dbg_state;
  wire        sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .MEM_DEPTH(256), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---- scoreboard ----
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [15:0] exp_wr_e;
  logic        watch_quiet = 1'b0;
  logic        oe_seen     = 1'b0;
  logic        busy_seen   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_q.size() == 0) begin
        chk("wr_spurious", 32'(wr_strobe), 32'd0);
      end else begin
        exp_wr_e = exp_q.pop_front();
        chk("wr_commit", {16'd0, wr_addr, wr_data}, {16'd0, exp_wr_e});
      end
    end
    if (watch_quiet) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
    end
  end

  // ---- driver tasks (SCL period = 16 clk) ----
  task automatic q_wait();
    repeat (4) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    q_wait();
    scl_m = 1'b1; q_wait(); q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    b = sda_line; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    chk(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic rd_byte(input logic master_ack, input string tag);
    logic [7:0] d;
    logic [7:0] e;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    // Acknowledge slot: the slave must have let go of SDA.
    sda_m = master_ack; q_wait();
    scl_m = 1'b1;       q_wait();
    chk({tag, "_rel9"}, 32'(sda_oe), 32'd0);
    q_wait();
    scl_m = 1'b0;       q_wait();
    if (exp_rd_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'(d), 32'hFFFF_FFFF);
    end else begin
      e = exp_rd_q.pop_front();
      chk(tag, 32'(d), 32'(e));
    end
  endtask

  task automatic set_ptr(input logic [7:0] a);
    start_c();
    wr_byte(8'hA0, I2C_ACK, "ptr_dev");
    wr_byte(a, I2C_ACK, "ptr_word");
  endtask

  task automatic settle_idle(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_oe"}, 32'(sda_oe), 32'd0);
  endtask

  // ---- watchdog ----
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---- stimulus ----
  logic       b;
  logic [7:0] rnd;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Byte write 0x02 <- 0xAB
    start_c();
    wr_byte(8'hA0, I2C_ACK, "bw_dev");
    chk("bw_busy", 32'(busy), 32'd1);
    wr_byte(8'h02, I2C_ACK, "bw_word");
    exp_q.push_back({8'h02, 8'hAB});
    wr_byte(8'hAB, I2C_ACK, "bw_data");
    stop_c();
    settle_idle("bw_end");

    // Random read of 0x02
    set_ptr(8'h02);
    start_c();
    wr_byte(8'hA1, I2C_ACK, "rr_dev");
    exp_rd_q.push_back(8'hAB);
    rd_byte(I2C_NACK, "rr_data");
    stop_c();
    settle_idle("rr_end");

    // Page write across the wrap, then sequential read back
    set_ptr(8'hFF);
    exp_q.push_back({8'hFF, 8'h11});
    wr_byte(8'h11, I2C_ACK, "wrap_d0");
    exp_q.push_back({8'h00, 8'h22});
    wr_byte(8'h22, I2C_ACK, "wrap_d1");
    stop_c();
    settle_idle("wrap_wend");
    set_ptr(8'hFF);
    start_c();
    wr_byte(8'hA1, I2C_ACK, "wrap_rdev");
    exp_rd_q.push_back(8'h11);
    rd_byte(I2C_ACK, "wrap_r0");
    exp_rd_q.push_back(8'h22);
    rd_byte(I2C_NACK, "wrap_r1");
    stop_c();
    settle_idle("wrap_rend");

    // Foreign device address: never acknowledged, never busy
    watch_quiet = 1'b1;
    start_c();
    wr_byte(8'hB0, I2C_NACK, "nm_dev");
    rnd = 8'($urandom_range(0, 255));
    wr_byte(rnd, I2C_NACK, "nm_b0");
    rnd = 8'($urandom_range(0, 255));
    wr_byte(rnd, I2C_NACK, "nm_b1");
    stop_c();
    watch_quiet = 1'b0;
    chk("nm_oe_seen", 32'(oe_seen), 32'd0);
    chk("nm_busy_seen", 32'(busy_seen), 32'd0);
    settle_idle("nm_end");

    // STOP after a partial data byte, memory untouched
    set_ptr(8'h02);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    stop_c();
    settle_idle("ab_end");
    set_ptr(8'h02);
    start_c();
    wr_byte(8'hA1, I2C_ACK, "ab_rdev");
    exp_rd_q.push_back(8'hAB);
    rd_byte(I2C_NACK, "ab_keep");
    stop_c();

    // A normal write after the abort is committed
    set_ptr(8'h05);
    exp_q.push_back({8'h05, 8'h5A});
    wr_byte(8'h5A, I2C_ACK, "aw_data");
    stop_c();
    set_ptr(8'h05);
    start_c();
    wr_byte(8'hA1, I2C_ACK, "aw_rdev");
    exp_rd_q.push_back(8'h5A);
    rd_byte(I2C_NACK, "aw_read");
    stop_c();
    settle_idle("aw_end");

    // Reset while the slave is driving a 0 bit (bit 6 of 0xAB)
    set_ptr(8'h02);
    start_c();
    wr_byte(8'hA1, I2C_ACK, "mr_dev");
    recv_bit(b);
    chk("mr_bit7", 32'(b), 32'd1);
    chk("mr_pre_oe", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_oe", 32'(sda_oe), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Current-address read starts from 0x00 after reset
    start_c();
    wr_byte(8'hA1, I2C_ACK, "ca_dev");
    exp_rd_q.push_back(8'h22);
    rd_byte(I2C_NACK, "ca_data");
    stop_c();
    settle_idle("ca_end");

    repeat (20) @(negedge clk);
    chk("wr_q_left", 32'(exp_q.size()), 32'd0);
    chk("rd_q_left", 32'(exp_rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
Synthesizable I2C responder that emulates a 24Cxx-style EEPROM with a single-byte word address, as the far end of the I2C master. It supports byte and page writes, current-address reads, random reads (dummy write, then repeated START) and sequential reads. It is oversampled by the system clock and drives SDA open-drain via an output-enable. It replaces the behavioural memory model in the test harness and is reusable as an on-chip register target.

Parameters:
DEV_ADDR, 7'h50, 7-bit device address; write address byte is 0xA0, read address byte is 0xA1.
MEM_DEPTH, 256, bytes of storage, power of two, at most 256.
AW, 8, word-address width; must equal log2(MEM_DEPTH).

Ports:
clk  in  1  system clock; must be at least 8x SCL frequency.
rst  in  1  synchronous, active-high reset.
scl_i  in  1  raw SCL from the pad; asynchronous.
sda_i  in  1  raw SDA from the pad; asynchronous.
sda_oe  out  1  1 = pull SDA low, 0 = release.
wr_strobe  out  1  one-cycle pulse per byte committed to memory.
wr_addr  out  AW  word address of the committed byte.
wr_data  out  8  committed byte.
busy  out  1  high from an address match until STOP, repeated START or NACK exit.

Behaviour:
- Input conditioning: 2-FF synchronizer on scl_i and sda_i, then 1-cycle edge detect; events lag the pins by 3 clk.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. These are detected in every state and take priority over bit handling.
- Bit sampling: a bit is shifted in, MSB first, on each synchronized SCL rising edge.
- Output changes: sda_oe changes only on the clk after a synchronized SCL falling edge, or on STOP, START or reset.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: on START, go to DEV_ADDR with bit counter = 0.
- DEV_ADDR, after 8 bits:
  - If [7:1] == DEV_ADDR, drive ACK from the next SCL fall and set busy.
  - R/W = 0: go to WORD_ADDR.
  - R/W = 1: go to RD_DATA.
  - Mismatch: no ACK; go to WAIT_STOP.
- ACK timing: sda_oe = 1 from the falling edge after bit 8 until the falling edge after the 9th clock.
- WORD_ADDR: after 8 bits, load ptr with the low AW bits and ACK.
- WR_DATA: after 8 bits, write mem[ptr], pulse wr_strobe with wr_addr = ptr and wr_data = byte, ACK, then ptr = ptr+1.
- Pointer wrap: ptr increments modulo MEM_DEPTH (0xFF goes to 0x00). There is no page boundary.
- RD_DATA:
  - Load shift register from mem[ptr] at the falling edge that ends the address ACK, or the previous master ACK.
  - Drive sda_oe = ~bit (MSB first) on each falling edge.
  - Release SDA for the 9th clock.
  - ptr = ptr+1 once the byte is loaded.
- RD_ACK: sample SDA on the 9th rising edge. Low (ACK): go to RD_DATA. High (NACK): go to WAIT_STOP with SDA released.
- Repeated START in any state: go to DEV_ADDR, release sda_oe, clear bit counter, keep ptr. This is what makes random read work.
- STOP in any state: go to IDLE, release sda_oe, clear busy. A partial byte is discarded with no write and no strobe.
- WAIT_STOP: ignore bits; leave only on STOP or START.
- Reset (also mid-transfer):
  - On the next clk: state IDLE, sda_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, busy = 0, ptr = 0, bit counter = 0.
  - Memory contents are not reset.
- Simultaneous events: SDA edge and SCL edge in the same cycle means SDA is treated as stable data. A START/STOP check uses the synchronized SCL level of the previous cycle.
- sda_oe is never asserted while SCL is high, except when holding an ACK or data bit that was already asserted.

Decomposition:
- i2c_pkg: FSM state enum, I2C_ACK = 1'b0, I2C_NACK = 1'b1.
- Sub-module i2c_line_sync: synchronizers, scl_rise, scl_fall, start_det, stop_det, sda_s. Shared with the master.

Test Plan:
- Byte write: START, 0xA0, 0x02, 0xAB, STOP -> ACK on all 3 bytes; one wr_strobe with wr_addr = 0x02, wr_data = 0xAB; busy low after STOP.
- Random read: START, 0xA0, 0x02, Sr, 0xA1, master NACK, STOP -> slave drives 0xAB MSB first; SDA released on the 9th clock; ends in IDLE.
- Sequential write/read with wrap: write at 0xFF data 0x11, 0x22 -> mem[0xFF] = 0x11, mem[0x00] = 0x22. Random read at 0xFF with master ACK, then NACK -> returns 0x11, 0x22.
- Address mismatch: 0xB0 followed by 2 bytes -> sda_oe stays 0 for the whole transaction; no wr_strobe; busy stays 0.
- Abort: STOP after 4 data bits -> no strobe and memory unchanged. A following 0xA0/0x05/0x5A write is ACKed and committed.
- Reset while driving a 0 read bit -> sda_oe = 0 and busy = 0 the next clk. A subsequent current-address read returns mem[0x00].
